bist_resp_checker: RTL and testbench
====================================

# bist_resp_checker

Downstream consumer of the 8-bit MISR in the BIST chain. Sequences one test session by pulsing the MISR clear, enabling the pattern generator for a fixed number of patterns, waiting out the CUT/MISR pipeline, and latching the final MISR signature. It compares the latched signature against a golden value and reports pass/fail to the top-level test controller.

## Interface
- `PAT_CNT`, default 255: number of patterns applied per session. Legal range is 1..65535.
- `PIPE_LAT`, default 1: settle cycles between the last pattern and signature capture. Legal range is 1..15.
- `GOLDEN_SIG`, default 8'hA5: expected MISR signature.
- `clk` input, 1 bit: single clock. All flops are rising-edge triggered.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: session request. Acted on only at a rising edge.
- `abort` input, 1 bit: terminates the session in progress.
- `sig` input, 8 bits: MISR `q` output.
- `misr_clr` output, 1 bit: one-cycle pulse wired to the MISR reset input.
- `tpg_en` output, 1 bit: enables the LFSR/TPG and marks the cycles the MISR is compacting.
- `busy` output, 1 bit: a session is in progress.
- `done` output, 1 bit: result is valid. Held until the next session starts or reset.
- `pass` output, 1 bit: `sig_q == GOLDEN_SIG`. Valid when `done` is high.
- `fail` output, 1 bit: `sig_q != GOLDEN_SIG`. Valid when `done` is high.
- `sig_q` output, 8 bits: captured signature, for diagnosis.

## Operation
- States: IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE.
- Start edge: `start` is registered into `start_d`. The edge condition is `start_rise = start & ~start_d`.
- IDLE to CLEAR on `start_rise`. DONE to CLEAR on `start_rise`, and `done`, `pass` and `fail` clear on that same edge.
- CLEAR: `misr_clr = 1` for exactly 1 cycle. Pattern counter loads 0. Next state is RUN.
- RUN:
  - `tpg_en = 1`. Counter increments each cycle.
  - Leave for SETTLE after `PAT_CNT` cycles in RUN, i.e. when the counter equals `PAT_CNT-1`.
  - Counter width is `$clog2(PAT_CNT+1)`. The counter never wraps.
- SETTLE: `tpg_en = 0`. Stays for `PIPE_LAT` cycles, reusing the counter reloaded to 0. Next state is COMPARE.
- COMPARE, one cycle:
  - `sig_q <= sig`.
  - `pass <= (sig == GOLDEN_SIG)`, `fail <= ~(sig == GOLDEN_SIG)`.
  - `done <= 1`. Next state is DONE.
- DONE: outputs hold. `start` held high does not relaunch; only a new rising edge does.
- Abort:
  - `abort` in CLEAR, RUN, SETTLE or COMPARE goes to IDLE at the next edge.
  - `tpg_en` deasserts, `done`, `pass` and `fail` stay 0, and `sig_q` is unchanged.
  - `abort` is ignored in IDLE and DONE.
  - Abort has priority over every other transition.
- `busy = 1` in CLEAR, RUN, SETTLE and COMPARE.
- Invariants:
  - `pass` and `fail` are mutually exclusive.
  - Both are 0 whenever `done = 0`.

## Timing
- Reset values:
  - State is IDLE and `start_d` is 0.
  - `misr_clr`, `tpg_en`, `busy`, `done`, `pass`, `fail` are all 0.
  - `sig_q` is 8'h00 and the counter is 0.
- Reset is asynchronous assert, including mid-session: every output returns to its reset value immediately. Deassertion is synchronised externally.
- `misr_clr` and `tpg_en` are registered outputs, decoded from the next state.
- Cycle counts, with edge 0 being the edge that samples `start_rise`:
  - `misr_clr` is high after edge 0, for 1 cycle.
  - `tpg_en` is high after edges 1..`PAT_CNT`.
  - `done` rises after edge `PAT_CNT + PIPE_LAT + 2`.
- `sig` is sampled at the COMPARE-exit edge. The MISR has absorbed the last response `PIPE_LAT` cycles earlier.
- `start_rise` and `abort` on the same edge:
  - In IDLE, the session starts.
  - In an active state, abort wins.

## Structure
- Shared package `bist_pkg` holds:
  - The state encoding constants (3 bits).
  - `SIG_W = 8`, shared with misr and the lfsr.
  - The default `GOLDEN_SIG`.
- One sub-module, `bist_pat_counter`:
  - Loadable up-counter with `clr`, `en` and a `hit` output for terminal-count compare.
  - Parameterised width.
  - Used for both RUN and SETTLE.
- The FSM, the start edge detector and the compare register sit in the top level.

## Test plan
All scenarios use `PAT_CNT=4`, `PIPE_LAT=1`, `GOLDEN_SIG=8'h3C` unless noted.
- Pass: start pulse, `sig=8'h3C` at COMPARE.
  - `misr_clr` is high 1 cycle, then `tpg_en` is high for 4 cycles.
  - `done` rises 7 edges after the start edge, with `pass=1`, `fail=0`, `sig_q=8'h3C`.
- Fail: same stimulus with `sig=8'h3D`.
  - `done=1`, `fail=1`, `pass=0`, `sig_q=8'h3D`.
- Abort in the 2nd RUN cycle: at the next edge the state is IDLE, `tpg_en=0`, `busy=0`, `done=0`.
  - A following start pulse produces a full, normal session.
- `start` held high for 20 cycles: exactly one session runs and `done` stays 1.
  - Dropping `start` low and then raising it again gives `done=0` at the next edge and a new `misr_clr` pulse.
- Async reset asserted mid-RUN, between clock edges: all outputs are 0 immediately and `sig_q=8'h00`.
  - After release, an idle `start=0` causes no activity.
- `PAT_CNT=1`, `PIPE_LAT=3`: `tpg_en` is high for exactly 1 cycle and `done` rises 6 edges after the start edge.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST chain: signature width, default golden
// signature, session FSM encoding and small helpers used by the checker.
package bist_pkg;

   localparam int SIG_W = 8;
   localparam logic [SIG_W-1:0] GOLDEN_SIG_DEF = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_RUN     = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_COMPARE = 3'd4,
      ST_DONE    = 3'd5
   } bist_state_e;

   // True for the states that make up an in-progress session.
   function automatic logic st_is_active(input bist_state_e st);
      return (st == ST_CLEAR) || (st == ST_RUN) ||
             (st == ST_SETTLE) || (st == ST_COMPARE);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bist_pat_counter.sv
// Saturating up-counter shared by the RUN and SETTLE phases.
//   clk   : clock (rising edge)
//   rst_n : asynchronous active-low reset
//   clr   : synchronous load of zero (wins over en)
//   en    : count enable
//   term  : terminal count for the phase in progress
//   hit   : current count equals term
module bist_pat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic         hit
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   logic [W-1:0] cnt_r;

   // Count register: clear has priority, and the count never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (clr) begin
         cnt_r <= {W{1'b0}};
      end else if (en && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign hit = (cnt_r == term);

endmodule

// File: rtl/bist_resp_checker.sv
// BIST session sequencer and MISR signature checker.
// Runs one session per rising edge of start: clear the MISR, enable the TPG
// for PAT_CNT cycles, wait PIPE_LAT settle cycles, then capture the MISR
// signature and compare it against GOLDEN_SIG.
//   clk      : clock (rising edge)
//   rst      : asynchronous active-low reset
//   start    : session request, acted on at its rising edge
//   abort    : terminates an in-progress session
//   sig      : MISR signature input
//   misr_clr : one-cycle MISR clear pulse
//   tpg_en   : pattern generator enable / MISR compaction window
//   busy     : session in progress
//   done     : result valid, held until the next session or reset
//   pass     : captured signature matches GOLDEN_SIG
//   fail     : captured signature differs from GOLDEN_SIG
//   sig_q    : captured signature
module bist_resp_checker
   import bist_pkg::*;
#(
   parameter int               PAT_CNT    = 255,
   parameter int               PIPE_LAT   = 1,
   parameter logic [SIG_W-1:0] GOLDEN_SIG = GOLDEN_SIG_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [SIG_W-1:0] sig,
   output logic             misr_clr,
   output logic             tpg_en,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [SIG_W-1:0] sig_q
);

   // The counter also times SETTLE, so it must hold PIPE_LAT-1 even when
   // PAT_CNT is tiny.
   localparam int CNT_W = max_int($clog2(PAT_CNT + 1), $clog2(PIPE_LAT + 1));
   localparam logic [CNT_W-1:0] RUN_TERM    = CNT_W'(PAT_CNT - 1);
   localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(PIPE_LAT - 1);

   bist_state_e      state_r;
   bist_state_e      state_nxt_s;
   logic             start_d_r;
   logic             start_rise_s;
   logic             cnt_clr_s;
   logic             cnt_en_s;
   logic [CNT_W-1:0] cnt_term_s;
   logic             cnt_hit_s;
   logic             capture_s;
   logic             sig_match_s;

   logic             misr_clr_r;
   logic             tpg_en_r;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;
   logic             fail_r;
   logic [SIG_W-1:0] sig_q_r;

   assign start_rise_s = start & ~start_d_r;
   assign sig_match_s  = (sig == GOLDEN_SIG);
   // An abort in COMPARE suppresses the capture.
   assign capture_s    = (state_r == ST_COMPARE) && !abort;

   bist_pat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst),
      .clr   (cnt_clr_s),
      .en    (cnt_en_s),
      .term  (cnt_term_s),
      .hit   (cnt_hit_s)
   );

   // Counter control: zero on the way into RUN and again into SETTLE.
   always_comb begin
      cnt_clr_s  = 1'b0;
      cnt_en_s   = 1'b0;
      cnt_term_s = RUN_TERM;
      if (state_r == ST_SETTLE) begin
         cnt_term_s = SETTLE_TERM;
      end else begin
         cnt_term_s = RUN_TERM;
      end
      if ((state_r == ST_CLEAR) || ((state_r == ST_RUN) && cnt_hit_s)) begin
         cnt_clr_s = 1'b1;
      end else begin
         cnt_clr_s = 1'b0;
      end
      if ((state_r == ST_RUN) || (state_r == ST_SETTLE)) begin
         cnt_en_s = 1'b1;
      end else begin
         cnt_en_s = 1'b0;
      end
   end

   // Next-state decode; abort takes priority in every active state.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_rise_s) state_nxt_s = ST_CLEAR;
            else              state_nxt_s = ST_IDLE;
         end
         ST_CLEAR: begin
            if (abort) state_nxt_s = ST_IDLE;
            else       state_nxt_s = ST_RUN;
         end
         ST_RUN: begin
            if (abort)          state_nxt_s = ST_IDLE;
            else if (cnt_hit_s) state_nxt_s = ST_SETTLE;
            else                state_nxt_s = ST_RUN;
         end
         ST_SETTLE: begin
            if (abort)          state_nxt_s = ST_IDLE;
            else if (cnt_hit_s) state_nxt_s = ST_COMPARE;
            else                state_nxt_s = ST_SETTLE;
         end
         ST_COMPARE: begin
            if (abort) state_nxt_s = ST_IDLE;
            else       state_nxt_s = ST_DONE;
         end
         ST_DONE: begin
            if (start_rise_s) state_nxt_s = ST_CLEAR;
            else              state_nxt_s = ST_DONE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State, start edge detector and outputs registered from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         start_d_r  <= 1'b0;
         misr_clr_r <= 1'b0;
         tpg_en_r   <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         pass_r     <= 1'b0;
         fail_r     <= 1'b0;
         sig_q_r    <= {SIG_W{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         start_d_r  <= start;
         misr_clr_r <= (state_nxt_s == ST_CLEAR);
         tpg_en_r   <= (state_nxt_s == ST_RUN);
         busy_r     <= st_is_active(state_nxt_s);
         done_r     <= (state_nxt_s == ST_DONE);
         if (capture_s) begin
            sig_q_r <= sig;
            pass_r  <= sig_match_s;
            fail_r  <= ~sig_match_s;
         end else if (state_nxt_s != ST_DONE) begin
            // Leaving DONE (or never reaching it) drops the verdict; the
            // captured signature stays for diagnosis.
            sig_q_r <= sig_q_r;
            pass_r  <= 1'b0;
            fail_r  <= 1'b0;
         end else begin
            sig_q_r <= sig_q_r;
            pass_r  <= pass_r;
            fail_r  <= fail_r;
         end
      end
   end

   assign misr_clr = misr_clr_r;
   assign tpg_en   = tpg_en_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign pass     = pass_r;
   assign fail     = fail_r;
   assign sig_q    = sig_q_r;

endmodule

// File: tb/tb_bist_resp_checker.sv
// Self-checking bench for bist_resp_checker. Two instances: A (PAT_CNT=4,
// PIPE_LAT=1) and B (PAT_CNT=1, PIPE_LAT=3), both with golden 8'h3C.
// Expected outputs come from a session-timeline model: a session is "age"
// edges old since its start edge; outputs follow from the age alone.
module tb_bist_resp_checker;

   localparam logic [7:0] GOLD = 8'h3C;
   localparam int PA = 4;
   localparam int LA = 1;
   localparam int PB = 1;
   localparam int LB = 3;

   typedef struct packed {
      bit         active;
      int         age;
      bit         done;
      bit         pass;
      bit         fail;
      logic [7:0] sigq;
      bit         start_prev;
   } mdl_t;

   logic       clk;
   logic       rst;
   logic       start, abort;
   logic [7:0] sig;
   logic       misr_clr, tpg_en, busy, done, pass, fail;
   logic [7:0] sig_q;
   logic       start2, abort2;
   logic [7:0] sig2;
   logic       misr_clr2, tpg_en2, busy2, done2, pass2, fail2;
   logic [7:0] sig_q2;

   int   n_checks;
   int   n_errors;
   mdl_t m_a;
   mdl_t m_b;

   bist_resp_checker #(.PAT_CNT(PA), .PIPE_LAT(LA), .GOLDEN_SIG(GOLD)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .sig(sig),
      .misr_clr(misr_clr), .tpg_en(tpg_en), .busy(busy), .done(done),
      .pass(pass), .fail(fail), .sig_q(sig_q)
   );

   bist_resp_checker #(.PAT_CNT(PB), .PIPE_LAT(LB), .GOLDEN_SIG(GOLD)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2), .sig(sig2),
      .misr_clr(misr_clr2), .tpg_en(tpg_en2), .busy(busy2), .done(done2),
      .pass(pass2), .fail(fail2), .sig_q(sig_q2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the session timeline by one clock edge.
   task automatic mdl_step(input mdl_t mi, input int p, input int l,
                           input bit st, input bit ab, input logic [7:0] s,
                           output mdl_t mo);
      bit rise;
      mo = mi;
      rise = st && !mi.start_prev;
      mo.start_prev = st;
      if (mi.active) begin
         if (ab) begin
            mo.active = 1'b0;
         end else begin
            mo.age = mi.age + 1;
            if (mo.age == p + l + 2) begin
               mo.active = 1'b0;
               mo.done   = 1'b1;
               mo.sigq   = s;
               mo.pass   = (s == GOLD);
               mo.fail   = (s != GOLD);
            end
         end
      end else if (rise) begin
         mo.active = 1'b1;
         mo.age    = 0;
         mo.done   = 1'b0;
         mo.pass   = 1'b0;
         mo.fail   = 1'b0;
      end
   endtask

   task automatic chk_out(input string pfx, input mdl_t m, input int p,
                          input logic mc, input logic te, input logic bz,
                          input logic dn, input logic ps, input logic fl,
                          input logic [7:0] sq);
      chk({pfx, "misr_clr"}, {31'd0, mc}, {31'd0, m.active && (m.age == 0)});
      chk({pfx, "tpg_en"},   {31'd0, te}, {31'd0, m.active && (m.age >= 1) && (m.age <= p)});
      chk({pfx, "busy"},     {31'd0, bz}, {31'd0, m.active});
      chk({pfx, "done"},     {31'd0, dn}, {31'd0, m.done});
      chk({pfx, "pass"},     {31'd0, ps}, {31'd0, m.pass});
      chk({pfx, "fail"},     {31'd0, fl}, {31'd0, m.fail});
      chk({pfx, "sig_q"},    {24'd0, sq}, {24'd0, m.sigq});
   endtask

   // Drive inputs, take one edge, update both models, compare both DUTs.
   task automatic step(input bit st, input bit ab, input logic [7:0] s,
                       input bit st2, input bit ab2, input logic [7:0] s2);
      mdl_t nx;
      start = st; abort = ab; sig = s;
      start2 = st2; abort2 = ab2; sig2 = s2;
      @(posedge clk);
      mdl_step(m_a, PA, LA, st, ab, s, nx);
      m_a = nx;
      mdl_step(m_b, PB, LB, st2, ab2, s2, nx);
      m_b = nx;
      #1;
      chk_out("a.", m_a, PA, misr_clr, tpg_en, busy, done, pass, fail, sig_q);
      chk_out("b.", m_b, PB, misr_clr2, tpg_en2, busy2, done2, pass2, fail2, sig_q2);
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "a_outs"}, {26'd0, misr_clr, tpg_en, busy, done, pass, fail}, 32'd0);
      chk({pfx, "a_sig_q"}, {24'd0, sig_q}, 32'd0);
      chk({pfx, "b_outs"}, {26'd0, misr_clr2, tpg_en2, busy2, done2, pass2, fail2}, 32'd0);
      chk({pfx, "b_sig_q"}, {24'd0, sig_q2}, 32'd0);
   endtask

   initial begin
      int first_done;
      int tpg_cnt;
      bit st_r, st2_r;
      n_checks = 0;
      n_errors = 0;
      m_a = '0;
      m_b = '0;
      rst = 1'b0;
      start = 1'b0; abort = 1'b0; sig = 8'h00;
      start2 = 1'b0; abort2 = 1'b0; sig2 = 8'h00;
      #1;
      chk_all_zero("reset.");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) step(1'b0, 1'b0, GOLD, 1'b0, 1'b0, 8'h00);

      // Pass session: done 7 edges after the start edge.
      step(1'b1, 1'b0, GOLD, 1'b0, 1'b0, 8'h00);
      chk("pass.misr_clr_edge0", {31'd0, misr_clr}, 32'd1);
      first_done = 0;
      tpg_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b0, GOLD, 1'b0, 1'b0, 8'h00);
         if (tpg_en) tpg_cnt++;
         if (done && (first_done == 0)) first_done = i;
      end
      chk("pass.done_edge", first_done, 32'd7);
      chk("pass.tpg_cycles", tpg_cnt, 32'd4);
      chk("pass.verdict", {30'd0, pass, fail}, 32'd2);
      chk("pass.sig_q", {24'd0, sig_q}, 32'h3C);

      // Fail session.
      step(1'b1, 1'b0, 8'h3D, 1'b0, 1'b0, 8'h00);
      repeat (10) step(1'b0, 1'b0, 8'h3D, 1'b0, 1'b0, 8'h00);
      chk("fail.verdict", {29'd0, done, pass, fail}, 32'd5);
      chk("fail.sig_q", {24'd0, sig_q}, 32'h3D);

      // Abort in the 2nd RUN cycle, then a clean session.
      step(1'b1, 1'b0, GOLD, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, GOLD, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, GOLD, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, GOLD, 1'b0, 1'b0, 8'h00);
      chk("abort.outs", {28'd0, tpg_en, busy, done, pass}, 32'd0);
      chk("abort.sig_q_kept", {24'd0, sig_q}, 32'h3D);
      step(1'b1, 1'b0, GOLD, 1'b0, 1'b0, 8'h00);
      repeat (10) step(1'b0, 1'b0, GOLD, 1'b0, 1'b0, 8'h00);
      chk("abort.rerun_pass", {29'd0, done, pass, fail}, 32'd6);

      // Start held high: a single session, done holds.
      repeat (20) step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00);
      chk("held.done", {30'd0, done, fail}, 32'd3);
      step(1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00);
      chk("held.relaunch", {29'd0, done, misr_clr, fail}, 32'd2);

      // Async reset mid-RUN, between edges.
      step(1'b0, 1'b0, GOLD, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, GOLD, 1'b0, 1'b0, 8'h00);
      #3;
      rst = 1'b0;
      #1;
      chk_all_zero("async_rst.");
      m_a = '0;
      m_b = '0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (4) step(1'b0, 1'b0, GOLD, 1'b0, 1'b0, 8'h00);
      chk("post_rst.idle", {27'd0, misr_clr, tpg_en, busy, done, pass}, 32'd0);

      // Instance B: PAT_CNT=1, PIPE_LAT=3.
      step(1'b0, 1'b0, GOLD, 1'b1, 1'b0, GOLD);
      first_done = 0;
      tpg_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b0, GOLD, 1'b0, 1'b0, GOLD);
         if (tpg_en2) tpg_cnt++;
         if (done2 && (first_done == 0)) first_done = i;
      end
      chk("b.done_edge", first_done, 32'd6);
      chk("b.tpg_cycles", tpg_cnt, 32'd1);
      chk("b.verdict", {30'd0, pass2, fail2}, 32'd2);

      // Randomized traffic on both instances.
      st_r = 1'b0;
      st2_r = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         logic [7:0] s1, s2;
         if ($urandom_range(0, 7) == 0) st_r = ~st_r;
         if ($urandom_range(0, 7) == 0) st2_r = ~st2_r;
         s1 = ($urandom_range(0, 2) == 0) ? GOLD : 8'($urandom);
         s2 = ($urandom_range(0, 2) == 0) ? GOLD : 8'($urandom);
         step(st_r, ($urandom_range(0, 29) == 0), s1,
              st2_r, ($urandom_range(0, 29) == 0), s2);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
